// File: rtl/pipe_pkg.sv
// pipe_pkg: shared encodings and helpers for the MEM pipeline stage.
// Access sizes, MEM FSM state encodings, the EX/MEM register layout
// and the store-lane helper functions.
package pipe_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACCESS = 1'b1;

    typedef struct packed {
        logic        valid;
        logic        regwr;
        logic [4:0]  rw;
        logic [31:0] alu;
        logic [31:0] stdata;
        logic        memrd;
        logic        memwr;
        logic [1:0]  size;
        logic        sgn;
        logic [1:0]  fpoint;
        logic [31:0] delayslot2;
        logic        jal;
    } exmem_t;

    // Byte enables for an access; low address bits below the access size are ignored.
    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << a;
            SZ_HALF: be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated onto every lane the size can occupy.
    function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] w;
        case (size)
            SZ_BYTE: w = {4{d[7:0]}};
            SZ_HALF: w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // Natural-alignment violation for half/word accesses.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        logic m;
        case (size)
            SZ_BYTE: m = 1'b0;
            SZ_HALF: m = a[0];
            default: m = (a != 2'b00);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: data-memory req/ack bus between the MEM stage
// (master) and the data memory (slave).
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/load_align.sv
// load_align: selects the addressed lane of a read word and zero- or
// sign-extends it to 32 bits. Purely combinational.
module load_align
    import pipe_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection and extension of the loaded value
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        data_o = 32'h0000_0000;
        case (addr_i)
            2'd0:    byte_s = rdata_i[7:0];
            2'd1:    byte_s = rdata_i[15:8];
            2'd2:    byte_s = rdata_i[23:16];
            default: byte_s = rdata_i[31:24];
        endcase
        if (addr_i[1]) begin
            half_s = rdata_i[31:16];
        end else begin
            half_s = rdata_i[15:0];
        end
        case (size_i)
            SZ_BYTE: data_o = {{24{signed_i & byte_s[7]}}, byte_s};
            SZ_HALF: data_o = {{16{signed_i & half_s[15]}}, half_s};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the 5-stage pipeline. Holds the EX/MEM
// register, sequences data-memory accesses over a req/ack bus with an ack
// timeout, steers store lanes and aligns load data for write-back.
// Build option MEM_MISALIGN_TRAP_EN: misaligned half/word accesses raise
// mem_fault and become bubbles instead of being force-aligned.
module mem_access_stage
    import pipe_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_regwr,
    input  logic [4:0]  ex_rw,
    input  logic [31:0] ex_alu,
    input  logic [31:0] ex_stdata,
    input  logic        ex_memrd,
    input  logic        ex_memwr,
    input  logic [1:0]  ex_size,
    input  logic        ex_signed,
    input  logic [1:0]  ex_fpoint,
    input  logic [31:0] ex_delayslot2,
    input  logic        ex_jal,
    output logic        mem_stall,
    mem_access_stage_if.master dmem,
    output logic        mem_fault,
    output logic        regwritein,
    output logic [4:0]  rwin,
    output logic [31:0] busWin,
    output logic [1:0]  fpointin,
    output logic [31:0] delayslot2in,
    output logic        jalin
);

    // Last counter value before the access is abandoned.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

    exmem_t          ex_s;
    exmem_t          exmem_d;
    exmem_t          exmem_q;
    logic [0:0]      state_d;
    logic [0:0]      state_q;
    logic [TO_W-1:0] cnt_d;
    logic [TO_W-1:0] cnt_q;

    logic        is_mem_ex_s;
    logic        is_mem_q_s;
    logic        trap_ex_s;
    logic        trap_q_s;
    logic        access_s;
    logic        ack_s;
    logic        timeout_s;
    logic        stall_s;
    logic        fault_s;
    logic [31:0] load_data_s;

    assign ex_s = '{valid:      ex_valid,
                    regwr:      ex_regwr,
                    rw:         ex_rw,
                    alu:        ex_alu,
                    stdata:     ex_stdata,
                    memrd:      ex_memrd,
                    memwr:      ex_memwr,
                    size:       ex_size,
                    sgn:        ex_signed,
                    fpoint:     ex_fpoint,
                    delayslot2: ex_delayslot2,
                    jal:        ex_jal};

    assign is_mem_ex_s = ex_valid & (ex_memrd | ex_memwr);
    assign is_mem_q_s  = exmem_q.valid & (exmem_q.memrd | exmem_q.memwr);

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap_ex_s = is_mem_ex_s & is_misaligned(ex_size, ex_alu[1:0]);
    assign trap_q_s  = is_mem_q_s & is_misaligned(exmem_q.size, exmem_q.alu[1:0]);
`else
    assign trap_ex_s = 1'b0;
    assign trap_q_s  = 1'b0;
`endif

    // The FSM enters ACCESS on the same edge that latches the memory op,
    // so the request is up in the first cycle the op sits in EX/MEM.
    assign access_s  = (state_q == S_ACCESS);
    assign ack_s     = access_s & dmem.dmem_ack;
    assign timeout_s = access_s & ~dmem.dmem_ack & (cnt_q == TO_LAST);
    assign stall_s   = access_s & ~ack_s & ~timeout_s;
    assign fault_s   = timeout_s | trap_q_s;

    assign mem_stall = stall_s;
    assign mem_fault = fault_s;

    load_align u_load_align (
        .size_i   (exmem_q.size),
        .signed_i (exmem_q.sgn),
        .addr_i   (exmem_q.alu[1:0]),
        .rdata_i  (dmem.dmem_rdata),
        .data_o   (load_data_s)
    );

    // EX/MEM next value: hold while stalled, otherwise take the EX stage
    always_comb begin
        exmem_d = exmem_q;
        if (stall_s) begin
            exmem_d = exmem_q;
        end else begin
            exmem_d = ex_s;
        end
    end

    // FSM next state: stay in ACCESS while waiting, re-enter for a back-to-back op
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE: begin
                if (is_mem_ex_s & ~trap_ex_s) begin
                    state_d = S_ACCESS;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (stall_s) begin
                    state_d = S_ACCESS;
                end else if (is_mem_ex_s & ~trap_ex_s) begin
                    state_d = S_ACCESS;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Timeout counter: counts un-acked ACCESS cycles, cleared otherwise
    always_comb begin
        cnt_d = {TO_W{1'b0}};
        if (stall_s) begin
            cnt_d = cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = {TO_W{1'b0}};
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            exmem_q <= '0;
            state_q <= S_IDLE;
            cnt_q   <= {TO_W{1'b0}};
        end else begin
            exmem_q <= exmem_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Data-memory bus drive, stable for the whole access
    always_comb begin
        dmem.dmem_req   = access_s;
        dmem.dmem_we    = access_s & exmem_q.memwr;
        dmem.dmem_addr  = 32'h0000_0000;
        dmem.dmem_be    = 4'b0000;
        dmem.dmem_wdata = 32'h0000_0000;
        if (access_s) begin
            dmem.dmem_addr = {exmem_q.alu[31:2], 2'b00};
            dmem.dmem_be   = store_be(exmem_q.size, exmem_q.alu[1:0]);
            if (exmem_q.memwr) begin
                dmem.dmem_wdata = store_wdata(exmem_q.size, exmem_q.stdata);
            end else begin
                dmem.dmem_wdata = 32'h0000_0000;
            end
        end else begin
            dmem.dmem_addr  = 32'h0000_0000;
            dmem.dmem_be    = 4'b0000;
            dmem.dmem_wdata = 32'h0000_0000;
        end
    end

    // Write-back outputs: bubble unless a valid op completes this cycle
    always_comb begin
        regwritein   = 1'b0;
        rwin         = 5'd0;
        busWin       = 32'h0000_0000;
        fpointin     = 2'd0;
        delayslot2in = 32'h0000_0000;
        jalin        = 1'b0;
        if (exmem_q.valid & ~stall_s & ~fault_s) begin
            regwritein   = exmem_q.regwr;
            rwin         = exmem_q.rw;
            busWin       = exmem_q.memrd ? load_data_s : exmem_q.alu;
            fpointin     = exmem_q.fpoint;
            delayslot2in = exmem_q.delayslot2;
            jalin        = exmem_q.jal;
        end else begin
            regwritein   = 1'b0;
            rwin         = 5'd0;
            busWin       = 32'h0000_0000;
            fpointin     = 2'd0;
            delayslot2in = 32'h0000_0000;
            jalin        = 1'b0;
        end
    end

endmodule
